// File: rtl/dm_arbiter_pkg.sv
// dm_arbiter_pkg: shared FSM states and widths for the data-memory arbiter
package dm_arbiter_pkg;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
endpackage

// File: rtl/dm_rsp_reg.sv
// dm_rsp_reg: one-cycle response register (valid/rdata/err) for one requester
//   in: clk, reset (async active-low), acc (beat accepted), we, mis (misaligned), rdata_in (DM read data)
//   out: valid, rdata (0 unless a good load), err
module dm_rsp_reg import dm_arbiter_pkg::*; (
  input  logic              clk,
  input  logic              reset,
  input  logic              acc,
  input  logic              we,
  input  logic              mis,
  input  logic [DATA_W-1:0] rdata_in,
  output logic              valid,
  output logic [DATA_W-1:0] rdata,
  output logic              err
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      valid <= 1'b0;
      rdata <= '0;
      err   <= 1'b0;
    end else begin
      valid <= acc;
      rdata <= (acc && !we && !mis) ? rdata_in : '0;
      err   <= acc && mis;
    end
endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-requester data-memory arbiter with lock bursts and 1-cycle responses
//   in: clk, reset (async active-low), reqN_valid/we/lock/addr/wdata, dm_out
//   out: reqN_ready, rspN_valid/rdata/err, mem_write, mem_addr_byte, mem_data
module dm_arbiter import dm_arbiter_pkg::*; #(
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic              req0_lock,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp0_err,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic              req1_lock,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              rsp1_err,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr_byte,
  output logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] dm_out
);
  state_t state, state_nxt;
  logic [CNT_W-1:0] burst_cnt, cnt_nxt;
  logic last_grant, last_nxt;
  logic own, full, v_own, v_oth, gany, gsel, we, lock, mis;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state      <= IDLE;
      burst_cnt  <= '0;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      burst_cnt  <= cnt_nxt;
      last_grant <= last_nxt;
    end
  // gsel picks requester 1 when set; gany says someone is granted at all
  always_comb begin
    own   = state == OWN1;
    full  = state != IDLE && burst_cnt == CNT_W'(MAX_BURST);
    v_own = own ? req1_valid : req0_valid;
    v_oth = own ? req0_valid : req1_valid;
    gany  = reset && (req0_valid || req1_valid);
    gsel  = (req0_valid && req1_valid) ? !last_grant : req1_valid;
    if (state != IDLE) gsel = full ? (v_oth ? !own : own) : (v_own ? own : gsel);
    addr  = gsel ? req1_addr : req0_addr;
    wdata = gsel ? req1_wdata : req0_wdata;
    we    = gsel ? req1_we : req0_we;
    lock  = gsel ? req1_lock : req0_lock;
    mis   = |addr[1:0];
    req0_ready    = gany && !gsel;
    req1_ready    = gany && gsel;
    mem_write     = gany && we && !mis;
    mem_addr_byte = gany ? addr : '0;
    mem_data      = gany ? wdata : '0;
    state_nxt = !gany ? state : lock ? (gsel ? OWN1 : OWN0) : IDLE;
    // counter saturates at MAX_BURST so a lone locked owner cannot wrap past the hand-over point
    cnt_nxt   = !gany ? burst_cnt : !lock ? '0 :
                (state == state_nxt) ? (full ? burst_cnt : burst_cnt + 1'b1) : CNT_W'(1);
    last_nxt  = gany ? gsel : last_grant;
  end
  dm_rsp_reg u_rsp0 (
    .clk(clk), .reset(reset), .acc(req0_ready), .we(we), .mis(mis), .rdata_in(dm_out),
    .valid(rsp0_valid), .rdata(rsp0_rdata), .err(rsp0_err)
  );
  dm_rsp_reg u_rsp1 (
    .clk(clk), .reset(reset), .acc(req1_ready), .we(we), .mis(mis), .rdata_in(dm_out),
    .valid(rsp1_valid), .rdata(rsp1_rdata), .err(rsp1_err)
  );
endmodule
